// File: rtl/vram_arbiter_if.sv
// Signal bundle between the VGA reader, the game logic and the state RAM.
// The arbiter uses the slave modport; the surrounding system uses master.
interface vram_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic          vga_re;
  logic [AW-1:0] vga_raddr;
  logic [DW-1:0] vga_rdata;
  logic          vga_rvalid;
  logic          vga_miss;

  logic          game_req;
  logic          game_we;
  logic [AW-1:0] game_addr;
  logic [DW-1:0] game_wdata;
  logic          game_ready;
  logic          game_ack;
  logic [DW-1:0] game_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  vga_re, vga_raddr, game_req, game_we, game_addr, game_wdata, mem_rdata,
    output vga_rdata, vga_rvalid, vga_miss, game_ready, game_ack, game_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output vga_re, vga_raddr, game_req, game_we, game_addr, game_wdata, mem_rdata,
    input  vga_rdata, vga_rvalid, vga_miss, game_ready, game_ack, game_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port state RAM arbiter: VGA reads have priority, game ops wait in a one-entry buffer.
// Define VRAM_STARVE_GUARD_EN to force a starved game op through after STARVE_LIMIT cycles.
module vram_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 64
) (
  input logic            clk,
  input logic            reset,
  vram_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_e        state_q;
  logic          buf_we_q;
  logic [AW-1:0] buf_addr_q;
  logic [DW-1:0] buf_wdata_q;
  logic [SW-1:0] starve_q;
  logic          vga_rvalid_q;
  logic          vga_miss_q;
  logic          game_ack_q;
  logic [DW-1:0] vga_rdata_q;
  logic [DW-1:0] game_rdata_q;

  logic          ready_s;
  logic          xfer_s;
  logic          force_s;
  logic          grant_game_s;
  logic          grant_vga_s;
  logic          mem_en_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_addr_s;
  logic [DW-1:0] mem_wdata_s;

  assign ready_s = (state_q != PEND);
  assign xfer_s  = bus.game_req && ready_s;

`ifdef VRAM_STARVE_GUARD_EN
  assign force_s = (starve_q == SW'(STARVE_LIMIT));
`else
  assign force_s = 1'b0;
`endif

  assign grant_game_s = (state_q == PEND) && (!bus.vga_re || force_s);
  assign grant_vga_s  = bus.vga_re && !grant_game_s;

  // RAM port follows the grant directly so the access lands this cycle
  always_comb begin
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    if (grant_game_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = buf_we_q;
      mem_addr_s  = buf_addr_q;
      mem_wdata_s = buf_wdata_q;
    end else if (grant_vga_s) begin
      mem_en_s    = 1'b1;
      mem_addr_s  = bus.vga_raddr;
    end else begin
      mem_en_s    = 1'b0;
    end
  end

  // Arbitration FSM, game buffer, starve counter and response flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      buf_we_q     <= 1'b0;
      buf_addr_q   <= '0;
      buf_wdata_q  <= '0;
      starve_q     <= '0;
      vga_rvalid_q <= 1'b0;
      vga_miss_q   <= 1'b0;
      game_ack_q   <= 1'b0;
      vga_rdata_q  <= '0;
      game_rdata_q <= '0;
    end else begin
      vga_rvalid_q <= grant_vga_s;
      vga_miss_q   <= bus.vga_re && grant_game_s;
      game_ack_q   <= 1'b0;
      if (vga_rvalid_q) begin
        vga_rdata_q <= bus.mem_rdata;
      end
      if (game_ack_q && !buf_we_q) begin
        game_rdata_q <= bus.mem_rdata;
      end
      case (state_q)
        IDLE: begin
          if (xfer_s) begin
            buf_we_q    <= bus.game_we;
            buf_addr_q  <= bus.game_addr;
            buf_wdata_q <= bus.game_wdata;
            state_q     <= PEND;
          end
        end
        PEND: begin
          if (grant_game_s) begin
            game_ack_q <= 1'b1;
            state_q    <= ACK;
          end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_q <= starve_q + SW'(1);
          end
        end
        ACK: begin
          starve_q <= '0;
          if (xfer_s) begin
            buf_we_q    <= bus.game_we;
            buf_addr_q  <= bus.game_addr;
            buf_wdata_q <= bus.game_wdata;
            state_q     <= PEND;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data is live from the RAM in the valid cycle, then held
  assign bus.vga_rdata  = vga_rvalid_q ? bus.mem_rdata : vga_rdata_q;
  assign bus.game_rdata = (game_ack_q && !buf_we_q) ? bus.mem_rdata : game_rdata_q;
  assign bus.vga_rvalid = vga_rvalid_q;
  assign bus.vga_miss   = vga_miss_q;
  assign bus.game_ack   = game_ack_q;
  assign bus.game_ready = ready_s;
  assign bus.mem_en     = mem_en_s;
  assign bus.mem_we     = mem_we_s;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_wdata  = mem_wdata_s;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a RAM model and scoreboard queues for VGA and game reads.
module tb_vram_arbiter;
  logic clk;
  logic reset;

  vram_arbiter_if #(.AW(10), .DW(16)) bus ();

  vram_arbiter #(.AW(10), .DW(16), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] ram    [0:1023] = '{default: 16'h0000};
  logic [15:0] refmem [0:1023] = '{default: 16'h0000};

  // Synchronous single-port RAM
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  int          nvec;
  int          nerr;
  int          n_rvalid;
  int          n_ack;
  int          n_miss;
  bit          track_vga;
  logic [15:0] exp_grd;
  logic [15:0] vq [$];
  logic [15:0] gq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.vga_rvalid) begin
      n_rvalid++;
      if (track_vga) begin
        if (vq.size() == 0) chk("vga_spurious", 32'(bus.vga_rvalid), 32'h0);
        else                chk("vga_rdata", 32'(bus.vga_rdata), 32'(vq.pop_front()));
      end
    end
    if (bus.vga_miss) n_miss++;
    if (bus.game_ack) begin
      n_ack++;
      if (gq.size() == 0) chk("ack_spurious", 32'(bus.game_ack), 32'h0);
      else                chk("game_rdata", 32'(bus.game_rdata), 32'(gq.pop_front()));
    end
    bus.vga_re   = 1'b0;
    bus.game_req = 1'b0;
  endtask

  task automatic game(input logic we, input logic [9:0] a, input logic [15:0] d);
    bus.game_req   = 1'b1;
    bus.game_we    = we;
    bus.game_addr  = a;
    bus.game_wdata = d;
    if (we) begin
      gq.push_back(exp_grd);
      refmem[a] = d;
    end else begin
      exp_grd = refmem[a];
      gq.push_back(exp_grd);
    end
  endtask

  task automatic vga(input logic [9:0] a);
    bus.vga_re    = 1'b1;
    bus.vga_raddr = a;
    if (track_vga) vq.push_back(refmem[a]);
  endtask

  initial begin
    int ack_b;
    int rv_b;
    int miss_b;
    logic [9:0] va;
    nvec = 0; nerr = 0; n_rvalid = 0; n_ack = 0; n_miss = 0;
    track_vga = 1'b1;
    exp_grd = 16'h0000;
    reset = 1'b1;
    bus.vga_re = 1'b0; bus.vga_raddr = 10'h000;
    bus.game_req = 1'b0; bus.game_we = 1'b0; bus.game_addr = 10'h000; bus.game_wdata = 16'h0000;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid", 32'(bus.vga_rvalid), 32'h0);
    chk("rst_ack",    32'(bus.game_ack),   32'h0);
    chk("rst_miss",   32'(bus.vga_miss),   32'h0);
    chk("rst_vrdata", 32'(bus.vga_rdata),  32'h0);
    chk("rst_grdata", 32'(bus.game_rdata), 32'h0);
    chk("rst_ready",  32'(bus.game_ready), 32'h1);
    chk("rst_mem_en", 32'(bus.mem_en),     32'h0);
    reset = 1'b0;

    // Idle game write, then read back
    game(1'b1, 10'h3FF, 16'h1234);
    settle();
    chk("wr_ready", 32'(bus.game_ready), 32'h1);
    chk("wr_idle_en", 32'(bus.mem_en), 32'h0);
    tick(); settle();
    chk("wr_pend_ready", 32'(bus.game_ready), 32'h0);
    chk("wr_issue_en",   32'(bus.mem_en),     32'h1);
    chk("wr_issue_we",   32'(bus.mem_we),     32'h1);
    chk("wr_issue_addr", 32'(bus.mem_addr),   32'h3FF);
    chk("wr_issue_data", 32'(bus.mem_wdata),  32'h1234);
    chk("wr_early_ack",  32'(bus.game_ack),   32'h0);
    tick(); settle();
    chk("wr_ack",    32'(bus.game_ack), 32'h1);
    chk("wr_ack_en", 32'(bus.mem_en),   32'h0);
    tick();
    game(1'b0, 10'h3FF, 16'h0000);
    tick(); settle();
    chk("rd_issue_we",   32'(bus.mem_we),   32'h0);
    chk("rd_issue_addr", 32'(bus.mem_addr), 32'h3FF);
    tick(); settle();
    chk("rd_ack",  32'(bus.game_ack),   32'h1);
    chk("rd_data", 32'(bus.game_rdata), 32'h1234);
    tick(); settle();
    chk("rd_hold", 32'(bus.game_rdata), 32'h1234);

    // Isolated and back-to-back VGA reads
    game(1'b1, 10'h005, 16'hBEEF);
    repeat (3) tick();
    vga(10'h005);
    settle();
    chk("vga_en",   32'(bus.mem_en),   32'h1);
    chk("vga_we",   32'(bus.mem_we),   32'h0);
    chk("vga_addr", 32'(bus.mem_addr), 32'h005);
    tick(); settle();
    chk("vga_valid",  32'(bus.vga_rvalid), 32'h1);
    chk("vga_beef",   32'(bus.vga_rdata),  32'hBEEF);
    tick(); settle();
    chk("vga_valid_off", 32'(bus.vga_rvalid), 32'h0);
    vga(10'h005);
    tick();
    vga(10'h3FF);
    settle();
    chk("b2b_valid0", 32'(bus.vga_rvalid), 32'h1);
    tick(); settle();
    chk("b2b_valid1", 32'(bus.vga_rvalid), 32'h1);
    chk("b2b_data1",  32'(bus.vga_rdata),  32'h1234);
    tick();

    // Game write under 10 cycles of continuous VGA reads
    ack_b = n_ack;
    rv_b  = n_rvalid;
    for (int i = 0; i < 10; i++) begin
      va = (i % 2 == 1) ? 10'h3FF : 10'h005;
      vga(va);
      if (i == 0) game(1'b1, 10'h020, 16'hA5A5);
      settle();
      chk("cont_vga_addr", 32'(bus.mem_addr), 32'(va));
      chk("cont_no_issue", 32'(bus.mem_we),   32'h0);
      tick();
    end
    settle();
    chk("cont_issue_we",   32'(bus.mem_we),   32'h1);
    chk("cont_issue_addr", 32'(bus.mem_addr), 32'h020);
    chk("cont_no_ack",     32'(n_ack - ack_b), 32'h0);
    tick(); settle();
    chk("cont_ack",        32'(bus.game_ack),    32'h1);
    chk("cont_rvalid_cnt", 32'(n_rvalid - rv_b), 32'd10);
    tick();

    // Simultaneous VGA read and game read, then accepts during ACK
    vga(10'h005);
    game(1'b0, 10'h020, 16'h0000);
    settle();
    chk("sim_vga_addr", 32'(bus.mem_addr), 32'h005);
    chk("sim_vga_we",   32'(bus.mem_we),   32'h0);
    tick(); settle();
    chk("sim_vga_valid",  32'(bus.vga_rvalid), 32'h1);
    chk("sim_issue_en",   32'(bus.mem_en),     32'h1);
    chk("sim_issue_addr", 32'(bus.mem_addr),   32'h020);
    tick(); settle();
    chk("sim_ack",       32'(bus.game_ack),   32'h1);
    chk("sim_rdata",     32'(bus.game_rdata), 32'hA5A5);
    chk("ack_ready",     32'(bus.game_ready), 32'h1);
    game(1'b1, 10'h030, 16'h1111);
    tick(); settle();
    chk("ackacc_pend",  32'(bus.game_ready), 32'h0);
    chk("ackacc_we",    32'(bus.mem_we),     32'h1);
    chk("ackacc_addr",  32'(bus.mem_addr),   32'h030);
    tick(); settle();
    chk("waw_ack", 32'(bus.game_ack), 32'h1);
    game(1'b0, 10'h030, 16'h0000);
    tick(); settle();
    chk("raw_issue_addr", 32'(bus.mem_addr), 32'h030);
    tick(); settle();
    chk("raw_rdata", 32'(bus.game_rdata), 32'h1111);
    tick();

    // Game op under 20 cycles of VGA reads: starvation behaviour
    track_vga = 1'b0;
    ack_b  = n_ack;
    rv_b   = n_rvalid;
    miss_b = n_miss;
    for (int i = 0; i < 20; i++) begin
      vga(10'h005);
      if (i == 0) game(1'b1, 10'h050, 16'h7777);
      tick();
    end
`ifdef VRAM_STARVE_GUARD_EN
    chk("guard_ack",    32'(n_ack - ack_b),     32'd1);
    chk("guard_miss",   32'(n_miss - miss_b),   32'd1);
    chk("guard_rvalid", 32'(n_rvalid - rv_b),   32'd19);
`else
    chk("starve_no_ack", 32'(n_ack - ack_b),   32'd0);
    chk("starve_no_miss", 32'(n_miss - miss_b), 32'd0);
    chk("starve_rvalid", 32'(n_rvalid - rv_b), 32'd20);
    settle();
    chk("starve_issue_addr", 32'(bus.mem_addr), 32'h050);
    tick(); settle();
    chk("starve_late_ack", 32'(bus.game_ack), 32'h1);
`endif
    tick();
    track_vga = 1'b1;

    // Reset while a game op is pending: it must vanish
    vga(10'h005);
    bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 10'h040; bus.game_wdata = 16'hDEAD;
    tick();
    bus.vga_re = 1'b1; bus.vga_raddr = 10'h3FF;
    settle();
    chk("rst2_pend", 32'(bus.game_ready), 32'h0);
    reset = 1'b1;
    bus.vga_re = 1'b0;
    settle();
    chk("rst2_en",     32'(bus.mem_en),     32'h0);
    chk("rst2_rvalid", 32'(bus.vga_rvalid), 32'h0);
    chk("rst2_vrdata", 32'(bus.vga_rdata),  32'h0);
    chk("rst2_grdata", 32'(bus.game_rdata), 32'h0);
    chk("rst2_ack",    32'(bus.game_ack),   32'h0);
    chk("rst2_ready",  32'(bus.game_ready), 32'h1);
    ack_b = n_ack;
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
    settle();
    chk("rst2_no_ack",    32'(n_ack - ack_b),  32'd0);
    chk("rst2_ready_out", 32'(bus.game_ready), 32'h1);
    chk("rst2_idle_en",   32'(bus.mem_en),     32'h0);
    vga(10'h040);
    tick(); settle();
    chk("rst2_not_written", 32'(bus.vga_rvalid), 32'h1);
    tick();

    chk("vq_empty", 32'(vq.size()), 32'd0);
    chk("gq_empty", 32'(gq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
